sin_input_wrapper: RTL



---
 rtl/sin_input_wrapper.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sin_input_wrapper.sv
// sin_input_wrapper
// Upstream neighbour of the sine output stage. Wins the shared 8-bit bus via
// a req/gnt handshake and collects one operand, low byte first. It then hands
// the assembled DATA_W-bit two's-complement angle to the sine core with a
// single start pulse. No new operand is accepted until the core reports done.
//
// State table
//   state   | meaning
//   IDLE    | nothing in flight, waiting for data_ready
//   REQ     | requesting the bus, waiting for gnt (bus not sampled)
//   RECV    | granted, capturing one byte per cycle while gnt holds
//   ACK     | operand complete, ack pulse, x loads on exit
//   START   | start pulse to the sine core, x stable
//   WAIT    | core running, waiting for done
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   data_ready : source has an operand (level, held until ack)
//   gnt        : bus arbiter grant (level)
//   inputbus   : shared 8-bit data bus
//   done       : sine core finished
//   req        : bus request to the arbiter
//   ack        : one-cycle pulse, operand fully received
//   start      : one-cycle pulse to the sine core
//   x          : registered operand to the sine core
//   busy       : high in every state except IDLE
module sin_input_wrapper #(
    parameter int DATA_W = 16,
    parameter int BYTES  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_ready,
    input  logic              gnt,
    input  logic [7:0]        inputbus,
    input  logic              done,
    output logic              req,
    output logic              ack,
    output logic              start,
    output logic [DATA_W-1:0] x,
    output logic              busy
);

    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_ACK,
        S_START,
        S_WAIT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] asm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        ack       = 1'b0;
        start     = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (data_ready) state_nxt = S_REQ;
            end
            S_REQ: begin
                req = 1'b1;
                if (gnt) state_nxt = S_RECV;
            end
            S_RECV: begin
                req = 1'b1;
                // Losing the grant mid-operand restarts the whole operand.
                if (!gnt)               state_nxt = S_REQ;
                else if (count == LAST) state_nxt = S_ACK;
            end
            S_ACK: begin
                ack       = 1'b1;
                state_nxt = S_START;
            end
            S_START: begin
                start     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (done) state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            asm_q <= '0;
            x     <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (gnt) count <= '0;
                end
                S_RECV: begin
                    if (gnt) begin
                        for (int i = 0; i < BYTES; i++) begin
                            if (count == CNT_W'(i)) asm_q[i*8 +: 8] <= inputbus;
                        end
                        if (count != LAST) count <= count + 1'b1;
                    end else begin
                        count <= '0;
                        asm_q <= '0;
                    end
                end
                // x only ever changes here, so it is stable from START on.
                S_ACK: begin
                    x <= asm_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
